// File: rtl/masku_result_packer.sv
// Mask-unit result packer: merges compressed per-element compare bits
// into full-datapath mask words seeded from the old destination register.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   start_valid_i/ready  vinsn request handshake (vl_i, vsew_i latched)
//   vd_old_*             old destination mask word, one per output word
//   beat_*               compressed compare bits plus bit enables
//   vrf_pnt_o            bit offset of the next beat inside the current word
//   result_*             packed word towards the lane write-back
//   done_o               one-cycle pulse once the vinsn is fully written
module masku_result_packer #(
    parameter int unsigned NrLanes = 4,
    parameter int unsigned ELEN    = 64,
    parameter int unsigned MaxVl   = 4096,
    localparam int unsigned DW     = NrLanes * ELEN,
    localparam int unsigned VlW    = $clog2(MaxVl) + 1,
    localparam int unsigned PntW   = $clog2(DW) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_valid_i,
    output logic            start_ready_o,
    input  logic [VlW-1:0]  vl_i,
    input  logic [1:0]      vsew_i,
    input  logic            vd_old_valid_i,
    output logic            vd_old_ready_o,
    input  logic [DW-1:0]   vd_old_i,
    input  logic            beat_valid_i,
    output logic            beat_ready_o,
    input  logic [DW-1:0]   beat_data_i,
    input  logic [DW-1:0]   beat_enable_i,
    output logic [PntW-1:0] vrf_pnt_o,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [DW-1:0]   result_data_o,
    output logic            result_last_o,
    output logic            done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACCUM,
        S_EMIT,
        S_DONE
    } state_e;

    state_e          r_state;
    state_e          w_state_nxt;

    logic [DW-1:0]   r_acc;
    logic [VlW-1:0]  r_vl;
    logic [1:0]      r_vsew;
    logic [VlW-1:0]  r_elem_cnt;
    logic [PntW-1:0] r_pnt;

    logic [VlW-1:0]  w_beat_elems;
    logic [VlW-1:0]  w_remain;
    logic [VlW-1:0]  w_step;
    logic [VlW-1:0]  w_elem_nxt;
    logic [PntW-1:0] w_pnt_nxt;
    logic            w_beat_end;
    logic            w_last;

    // One beat carries NrLanes*8 bytes worth of compare results, so the
    // number of elements it covers shrinks with the source element width.
    always_comb begin
        w_beat_elems = VlW'(NrLanes * 8) >> r_vsew;
        w_remain     = r_vl - r_elem_cnt;
        w_step       = (w_beat_elems < w_remain) ? w_beat_elems : w_remain;
        w_elem_nxt   = r_elem_cnt + w_step;
        // step never exceeds one beat, so it always fits the pointer width
        w_pnt_nxt    = r_pnt + PntW'(w_step);
        w_beat_end   = (w_pnt_nxt == PntW'(DW)) || (w_elem_nxt == r_vl);
        w_last       = (r_elem_cnt == r_vl);
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start_valid_i) begin
                    w_state_nxt = (vl_i == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (vd_old_valid_i) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (beat_valid_i && w_beat_end) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (result_ready_i) begin
                    w_state_nxt = w_last ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        start_ready_o  = 1'b0;
        vd_old_ready_o = 1'b0;
        beat_ready_o   = 1'b0;
        result_valid_o = 1'b0;
        result_data_o  = '0;
        result_last_o  = 1'b0;
        done_o         = 1'b0;
        unique case (r_state)
            S_IDLE:  start_ready_o  = 1'b1;
            S_LOAD:  vd_old_ready_o = 1'b1;
            S_ACCUM: beat_ready_o   = 1'b1;
            S_EMIT: begin
                result_valid_o = 1'b1;
                result_data_o  = r_acc;
                result_last_o  = w_last;
            end
            S_DONE:  done_o         = 1'b1;
            default: ;
        endcase
    end

    assign vrf_pnt_o = r_pnt;

    // Datapath: the accumulator holds the word in flight; it only moves on
    // an accepted handshake, which keeps result_data_o stable during EMIT.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_acc      <= '0;
            r_vl       <= '0;
            r_vsew     <= '0;
            r_elem_cnt <= '0;
            r_pnt      <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start_valid_i) begin
                        r_vl       <= vl_i;
                        r_vsew     <= vsew_i;
                        r_elem_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (vd_old_valid_i) begin
                        r_acc <= vd_old_i;
                        r_pnt <= '0;
                    end
                end
                S_ACCUM: begin
                    if (beat_valid_i) begin
                        r_acc      <= (r_acc & ~beat_enable_i)
                                    | (beat_data_i & beat_enable_i);
                        r_elem_cnt <= w_elem_nxt;
                        r_pnt      <= w_pnt_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
